// File: rtl/xor_mux_serial_subtractor_if.sv
// Handshake bundle for the digit-serial subtractor: operand request channel
// and result channel, each with its own valid/ready pair.
interface xor_mux_serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/xor_mux_serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = A + ~B + ~bin, DIGIT bits
// per clock through an XOR/MUX full-adder chain with a registered carry.
module xor_mux_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                        clk,
  input logic                        rst,
  xor_mux_serial_subtractor_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               ovf_q;

  logic [WIDTH-1:0]   sa_q;
  logic [WIDTH-1:0]   sb_q;
  logic               a_msb_q;
  logic               b_msb_q;

  logic [DIGIT-1:0]   digit_sum;
  logic               carry_d;
  logic [WIDTH-1:0]   res_d;
  logic               accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    carry_d   = carry_q;
    digit_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      digit_sum[i] = sa_q[i] ^ sb_q[i] ^ carry_d;
      // Propagate selects the incoming carry, otherwise generate/kill is a_i.
      carry_d      = (sa_q[i] ^ sb_q[i]) ? carry_d : sa_q[i];
    end
  end

  // Completed digits accumulate below the digit being produced this cycle.
  generate
    if (N > 1) begin : g_multi
      logic [WIDTH-DIGIT-1:0] part_q;
      assign res_d = {digit_sum, part_q};
      always_ff @(posedge clk) begin
        if (state_q == RUN) part_q <= res_d[WIDTH-1:DIGIT];
      end
    end else begin : g_single
      assign res_d = digit_sum;
    end
  endgenerate

  // NOTE: operand shift registers carry no reset; they are always reloaded on
  // accept before being read, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q    <= bus.A;
      sb_q    <= ~bus.B;
      a_msb_q <= bus.A[WIDTH-1];
      b_msb_q <= bus.B[WIDTH-1];
    end else if (state_q == RUN) begin
      sa_q <= sa_q >> DIGIT;
      sb_q <= sb_q >> DIGIT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q    <= RUN;
            carry_q    <= ~bus.bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            diff_q      <= res_d;
            bout_q      <= ~carry_d;
            ovf_q       <= (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_xor_mux_serial_subtractor.sv
// Self-checking bench: directed vectors with literal results plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_xor_mux_serial_subtractor;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  xor_mux_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  xor_mux_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide integer arithmetic, signed overflow from the true value.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                output logic [31:0] d, output logic bo, output logic ov);
    longint ua, ub, sa, sb, s;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = 32'(ua - ub - longint'(bi));
    bo = (ua < ub + longint'(bi));
    s  = sa - sb - longint'(bi);
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Per-cycle scoreboard.
  bit          pending;
  int          acc_edge;
  logic [31:0] exp_d;
  logic        exp_b;
  logic        exp_o;
  bit          tp_mode;
  bit          have_prev;
  int          prev_acc;

  initial begin
    pending   = 0;
    acc_edge  = 0;
    tp_mode   = 0;
    have_prev = 0;
    prev_acc  = 0;
  end

  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = pending && (cyc - acc_edge >= N);
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_valid});
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, (!rst && !pending)});
    if (exp_valid) begin
      check("diff", {32'd0, bus.diff}, {32'd0, exp_d});
      check("bout", {63'd0, bus.bout}, {63'd0, exp_b});
      check("ovf", {63'd0, bus.ovf}, {63'd0, exp_o});
    end
    if (rst) begin
      pending = 0;
    end else if (pending) begin
      if (exp_valid && bus.out_ready) pending = 0;
    end else if (bus.in_valid) begin
      pending  = 1;
      model(bus.A, bus.B, bus.bin, exp_d, exp_b, exp_o);
      acc_edge = cyc + 1;
      if (tp_mode) begin
        if (have_prev) check("throughput", acc_edge - prev_acc, N + 2);
        have_prev = 1;
        prev_acc  = acc_edge;
      end
    end
    if (!tp_mode) have_prev = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One complete operation from IDLE; literal expectations on the result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                       input int hold, input bit scramble,
                       input logic [31:0] ed, input logic eb, input logic eo);
    int k;
    bus.A = a; bus.B = b; bus.bin = bi;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 50) begin tick(); k++; end
    check("accept_wait", k, 0);
    tick();
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.A = $urandom; bus.B = $urandom; bus.bin = ~bi;
    end
    k = 0;
    while (!bus.out_valid && k < 50) begin tick(); k++; end
    check("latency", k, N);
    check("lit_diff", {32'd0, bus.diff}, {32'd0, ed});
    check("lit_bout", {63'd0, bus.bout}, {63'd0, eb});
    check("lit_ovf", {63'd0, bus.ovf}, {63'd0, eo});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_diff", {32'd0, bus.diff}, {32'd0, ed});
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] md;
    logic        mb, mo;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.bin = 1'b0;

    // Pin the model against hand-computed values.
    model(32'd5, 32'd3, 1'b0, md, mb, mo);
    check("model_5_3", {31'd0, md, mb, mo}, {31'd0, 32'h0000_0002, 1'b0, 1'b0});
    model(32'h8000_0000, 32'd1, 1'b0, md, mb, mo);
    check("model_min_1", {31'd0, md, mb, mo}, {31'd0, 32'h7FFF_FFFF, 1'b0, 1'b1});
    model(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, md, mb, mo);
    check("model_max_m1", {31'd0, md, mb, mo}, {31'd0, 32'h8000_0000, 1'b1, 1'b1});

    repeat (3) tick();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_diff", {32'd0, bus.diff}, 64'd0);
    check("rst_flags", {62'd0, bus.bout, bus.ovf}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();

    do_op(32'd5, 32'd3, 1'b0, 0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    do_op(32'd0, 32'd1, 1'b0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b0, 0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 5, 1'b0, 32'hDEAC_4111, 1'b0, 1'b0);
    do_op(32'd9, 32'd4, 1'b1, 0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);

    // Abort mid-operation, after the edge that leaves cnt at 3.
    bus.A = 32'hFFFF_FFFF; bus.B = 32'h0000_0001; bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    do_op(32'd100, 32'd58, 1'b0, 0, 1'b0, 32'd42, 1'b0, 1'b0);

    // Randomized traffic, including random back-pressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.A         = pick();
      bus.B         = pick();
      bus.bin       = 1'($urandom_range(1));
      bus.out_ready = 1'($urandom_range(1));
      rst           = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Sustained traffic with the consumer always ready.
    tp_mode = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6 * (N + 2) + 3; i++) begin
      bus.A   = $urandom;
      bus.B   = $urandom;
      bus.bin = 1'($urandom_range(1));
      tick();
    end
    bus.in_valid = 1'b0;
    tp_mode = 1'b0;
    repeat (N + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
